reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/eater_pkg.sv | 7 +
 rtl/reg_cell.sv | 67 ++++++
 rtl/reg_file.sv | 99 +++++++++
 3 files changed

// File: rtl/eater_pkg.sv
// Shared constants for the register-file slice: default data width and register count.
package eater_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_DEPTH = 4;

endpackage

// File: rtl/reg_cell.sv
// One WIDTH-bit register with synchronous clear, parallel load and optional up/down count.
// Counting logic exists only when REG_FILE_COUNT_EN is defined.
module reg_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value,
  output logic             wrap
);

  logic [WIDTH-1:0] value_r;
  logic [WIDTH-1:0] next_s;
  logic             wrap_s;

`ifdef REG_FILE_COUNT_EN
  // Next value: load outranks counting; up/down arrive already qualified as exclusive.
  always_comb begin
    next_s = value_r;
    wrap_s = 1'b0;
    if (load) begin
      next_s = data;
    end else if (up) begin
      next_s = value_r + {{(WIDTH-1){1'b0}}, 1'b1};
      wrap_s = &value_r;
    end else if (down) begin
      next_s = value_r - {{(WIDTH-1){1'b0}}, 1'b1};
      wrap_s = ~|value_r;
    end else begin
      next_s = value_r;
    end
  end
`else
  logic unused_count_s;
  assign unused_count_s = up ^ down;

  // Next value: load only.
  always_comb begin
    next_s = value_r;
    wrap_s = 1'b0;
    if (load) begin
      next_s = data;
    end else begin
      next_s = value_r;
    end
  end
`endif

  // Storage register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      value_r <= {WIDTH{1'b0}};
    end else begin
      value_r <= next_s;
    end
  end

  assign value      = value_r;
  assign next_value = next_s;
  assign wrap       = wrap_s;

endmodule

// File: rtl/reg_file.sv
// Register file: address decode, tri-state read port, registered zero/carry flags.
// Optional counting on cnt_addr is enabled by defining REG_FILE_COUNT_EN.
module reg_file
  import eater_pkg::*;
#(
  parameter  int WIDTH  = DATA_W,
  parameter  int DEPTH  = REG_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  bus,
  input  logic              enable,
  input  logic [ADDR_W-1:0] enable_addr,
  output logic [WIDTH-1:0]  bus_out,
  input  logic              inc,
  input  logic              dec,
  input  logic [ADDR_W-1:0] cnt_addr,
  output logic              zero,
  output logic              carry
);

  logic [DEPTH-1:0]            load_sel_s;
  logic [DEPTH-1:0]            up_sel_s;
  logic [DEPTH-1:0]            down_sel_s;
  logic                        count_ok_s;
  logic [DEPTH-1:0][WIDTH-1:0] value_s;
  logic [DEPTH-1:0][WIDTH-1:0] next_s;
  logic [DEPTH-1:0]            wrap_s;
  logic                        zero_r;
  logic                        carry_r;

`ifdef REG_FILE_COUNT_EN
  // Decode: a count is dropped when inc==dec or when it collides with a load.
  always_comb begin
    count_ok_s = (inc ^ dec) && !(load && (load_addr == cnt_addr));
    load_sel_s = {DEPTH{1'b0}};
    up_sel_s   = {DEPTH{1'b0}};
    down_sel_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      load_sel_s[i] = load && (load_addr == ADDR_W'(i));
      up_sel_s[i]   = count_ok_s && inc && (cnt_addr == ADDR_W'(i));
      down_sel_s[i] = count_ok_s && dec && (cnt_addr == ADDR_W'(i));
    end
  end
`else
  logic unused_count_s;
  assign unused_count_s = inc ^ dec;

  // Decode: load only.
  always_comb begin
    count_ok_s = 1'b0;
    load_sel_s = {DEPTH{1'b0}};
    up_sel_s   = {DEPTH{1'b0}};
    down_sel_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      load_sel_s[i] = load && (load_addr == ADDR_W'(i));
    end
  end
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk        (clk),
      .clear      (clear),
      .load       (load_sel_s[g]),
      .data       (bus),
      .up         (up_sel_s[g]),
      .down       (down_sel_s[g]),
      .value      (value_s[g]),
      .next_value (next_s[g]),
      .wrap       (wrap_s[g])
    );
  end

  // Flags: load decides zero when it writes; only the counted cell can raise wrap.
  always_ff @(posedge clk) begin
    if (clear) begin
      zero_r  <= 1'b1;
      carry_r <= 1'b0;
    end else begin
      carry_r <= |wrap_s;
      if (load) begin
        zero_r <= (bus == {WIDTH{1'b0}});
      end else if (count_ok_s) begin
        zero_r <= (next_s[cnt_addr] == {WIDTH{1'b0}});
      end else begin
        zero_r <= zero_r;
      end
    end
  end

  assign bus_out = enable ? value_s[enable_addr] : {WIDTH{1'bz}};
  assign zero    = zero_r;
  assign carry   = carry_r;

endmodule
